// File: rtl/quad_velocity_pkg.sv
// quad_velocity_pkg
// Shared definitions for the quadrature velocity stage: position width,
// measurement FSM state encoding and the signed saturation helper.
package quad_velocity_pkg;

   localparam int POS_W = 32;

   typedef enum logic {
      PRIME = 1'b0,   // waiting for the first window edge to seed prev
      RUN   = 1'b1    // every window edge produces a velocity sample
   } qvel_state_e;

   // Clamp a 32-bit two's-complement delta to the signed range of a w-bit
   // result. Arithmetic is done in 64 bits so w=32 (no clamping) needs no
   // special case. Returns the clamped value sign-extended to 32 bits.
   function automatic logic [POS_W-1:0] sat_clamp(
      input  logic [POS_W-1:0] d,
      input  int               w,
      output logic             clamped
   );
      longint dv;
      longint hi;
      longint lo;
      dv = longint'(signed'(d));
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -(longint'(1) <<< (w - 1));
      clamped = 1'b0;
      if (dv > hi) begin
         clamped = 1'b1;
         dv      = hi;
      end else if (dv < lo) begin
         clamped = 1'b1;
         dv      = lo;
      end
      return POS_W'(dv);
   endfunction

endpackage

// File: rtl/quad_velocity_if.sv
// quad_velocity_if
// Four-phase position snapshot handshake between host interface and the
// velocity stage.
//   snap_req  host -> stage, level request
//   snap_ack  stage -> host, acknowledge
//   snap_pos  stage -> host, captured position, stable while snap_ack=1
interface quad_velocity_if;
   import quad_velocity_pkg::*;

   logic             snap_req;
   logic             snap_ack;
   logic [POS_W-1:0] snap_pos;

   modport master (output snap_req, input  snap_ack, input  snap_pos);
   modport slave  (input  snap_req, output snap_ack, output snap_pos);
endinterface

// File: rtl/qvel_sync.sv
// qvel_sync
// Two-flop synchronizer for an asynchronous level plus one history flop for
// rising-edge detection.
//   clk, rst_n  clock, async active-low reset (all flops reset to 0)
//   d           asynchronous input
//   rise        one-cycle pulse on synchronized 0->1 transition
module qvel_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);
   logic s1, s2, s3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;
endmodule

// File: rtl/quad_velocity.sv
// quad_velocity
// Per-window position delta (velocity) with saturation, plus a coherent
// position snapshot handshake. Optional index capture is built when the
// macro QVEL_INDEX_EN is defined.
//   clk, rst_n      clock, async active-low reset
//   pos             encoder position count (same clock, wraps)
//   en              measurement enable; low re-primes the measurement
//   vel             signed counts per window, saturated to VEL_W bits
//   vel_valid       one-cycle strobe when vel updates
//   vel_sat         last vel result was clamped
//   snap            snapshot handshake (slave side)
//   index           raw async index input            (QVEL_INDEX_EN)
//   index_clr       clears index_seen, beats capture  (QVEL_INDEX_EN)
//   index_seen      sticky index-captured flag        (QVEL_INDEX_EN)
//   index_pos       position at captured index edge   (QVEL_INDEX_EN)
module quad_velocity
   import quad_velocity_pkg::*;
#(
   parameter int PERIOD = 1000,
   parameter int VEL_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [POS_W-1:0]        pos,
   input  logic                    en,
   output logic signed [VEL_W-1:0] vel,
   output logic                    vel_valid,
   output logic                    vel_sat,
   quad_velocity_if.slave          snap
`ifdef QVEL_INDEX_EN
   ,
   input  logic                    index,
   input  logic                    index_clr,
   output logic                    index_seen,
   output logic [POS_W-1:0]        index_pos
`endif
);
   localparam int TW = $clog2(PERIOD);

   logic [TW-1:0]    timer;
   logic             tick;
   qvel_state_e      state, state_nxt;
   logic             load_prev, load_vel;
   logic [POS_W-1:0] prev, delta, sat_val;
   logic             sat_flag;

   // Window timer; held at 0 while disabled so a restart always begins a
   // fresh window.
   assign tick = (timer == TW'(PERIOD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        timer <= '0;
      else if (!en)      timer <= '0;
      else if (tick)     timer <= '0;
      else               timer <= timer + 1'b1;
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= PRIME;
      else        state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      if (!en)       state_nxt = PRIME;
      else if (tick) state_nxt = RUN;
   end

   // FSM: outputs. PRIME only seeds prev; RUN seeds prev and emits a sample.
   always_comb begin
      load_prev = en && tick;
      load_vel  = en && tick && (state == RUN);
   end

   // Modular subtraction makes counter wrap transparent.
   always_comb begin
      sat_flag = 1'b0;
      delta    = pos - prev;
      sat_val  = sat_clamp(delta, VEL_W, sat_flag);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev      <= '0;
         vel       <= '0;
         vel_sat   <= 1'b0;
         vel_valid <= 1'b0;
      end else begin
         vel_valid <= load_vel;
         if (load_prev) prev <= pos;
         if (load_vel) begin
            vel     <= VEL_W'(sat_val);
            vel_sat <= sat_flag;
         end
      end
   end

   // Snapshot: capture only on a fresh request (ack low), so snap_pos stays
   // frozen for the whole time ack is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap.snap_ack <= 1'b0;
         snap.snap_pos <= '0;
      end else if (snap.snap_req && !snap.snap_ack) begin
         snap.snap_ack <= 1'b1;
         snap.snap_pos <= pos;
      end else if (!snap.snap_req && snap.snap_ack) begin
         snap.snap_ack <= 1'b0;
      end
   end

`ifdef QVEL_INDEX_EN
   logic index_rise;

   qvel_sync u_index_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (index),
      .rise  (index_rise)
   );

   // Clear has priority: an edge coinciding with index_clr is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         index_seen <= 1'b0;
         index_pos  <= '0;
      end else if (index_clr) begin
         index_seen <= 1'b0;
      end else if (index_rise && !index_seen) begin
         index_seen <= 1'b1;
         index_pos  <= pos;
      end
   end
`endif

endmodule

// File: tb/tb_quad_velocity.sv
// tb_quad_velocity
// Scoreboard bench for quad_velocity (PERIOD=4, VEL_W=16). Stimulus pushes
// expected velocity samples; a monitor pops one per vel_valid strobe.
// Index checks are built when QVEL_INDEX_EN is defined.
module tb_quad_velocity;

   typedef struct packed {
      logic signed [15:0] v;
      logic               s;
   } exp_t;

   logic               clk;
   logic               rst_n;
   logic               en;
   logic [31:0]        pos;
   logic signed [15:0] vel;
   logic               vel_valid;
   logic               vel_sat;
`ifdef QVEL_INDEX_EN
   logic               index;
   logic               index_clr;
   logic               index_seen;
   logic [31:0]        index_pos;
`endif

   quad_velocity_if snap_if ();

   int   nchk = 0;
   int   nfail = 0;
   exp_t expq[$];
   int   edge_cnt;
   int   first_valid;

   quad_velocity #(.PERIOD(4), .VEL_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pos       (pos),
      .en        (en),
      .vel       (vel),
      .vel_valid (vel_valid),
      .vel_sat   (vel_sat),
      .snap      (snap_if)
`ifdef QVEL_INDEX_EN
      ,
      .index     (index),
      .index_clr (index_clr),
      .index_seen(index_seen),
      .index_pos (index_pos)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int v, input bit s);
      exp_t e;
      e.v = 16'(v);
      e.s = s;
      expq.push_back(e);
   endtask

   // One posedge, then note the first vel_valid since edge_cnt was cleared.
   task automatic step_edge();
      @(posedge clk);
      #1;
      edge_cnt++;
      if (vel_valid && first_valid == 0) first_valid = edge_cnt;
   endtask

   // Hold pos for one full window; entered and left at a negedge with the
   // DUT timer at 0, so the window's tick samples p.
   task automatic window(input logic [31:0] p, input bit has_exp, input int ev, input bit es);
      if (has_exp) push_exp(ev, es);
      pos = p;
      repeat (4) step_edge();
      @(negedge clk);
   endtask

   // Monitor: one scoreboard pop per vel_valid strobe.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && vel_valid) begin
            nchk++;
            if (expq.size() == 0) begin
               nfail++;
               $display("FAIL vel_unexpected: vel_valid with vel=%0d sat=%0b, none expected", vel, vel_sat);
            end else begin
               e = expq.pop_front();
               if (vel !== e.v || vel_sat !== e.s) begin
                  nfail++;
                  $display("FAIL vel_sample: got vel=%0d sat=%0b expected vel=%0d sat=%0b",
                           vel, vel_sat, e.v, e.s);
               end
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      en = 1'b0;
      pos = '0;
      snap_if.snap_req = 1'b0;
      edge_cnt = 0;
      first_valid = 0;
`ifdef QVEL_INDEX_EN
      index = 1'b0;
      index_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vel", 32'(vel), 32'd0);
      chk("rst_vel_valid", 32'(vel_valid), 32'd0);
      chk("rst_vel_sat", 32'(vel_sat), 32'd0);
      chk("rst_snap_ack", 32'(snap_if.snap_ack), 32'd0);
      chk("rst_snap_pos", snap_if.snap_pos, 32'd0);
`ifdef QVEL_INDEX_EN
      chk("rst_index_seen", 32'(index_seen), 32'd0);
      chk("rst_index_pos", index_pos, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // pos +1 per cycle: windows sample 3,7,11,15 -> vel=4 from edge 8
      @(negedge clk);
      en = 1'b1;
      pos = 32'd0;
      edge_cnt = 0;
      first_valid = 0;
      repeat (3) push_exp(4, 1'b0);
      for (int i = 0; i < 16; i++) begin
         step_edge();
         @(negedge clk);
         pos = pos + 1;
      end
      chk("first_valid_after_en", 32'(first_valid), 32'd8);

      // prev=15 now
      window(32'd100, 1'b1, 85, 1'b0);

      // en dropped mid-window: vel holds, re-prime needed
      pos = 32'd200;
      repeat (2) @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("hold_vel_en_low", 32'(vel), 32'd85);
      chk("hold_sat_en_low", 32'(vel_sat), 32'd0);
      @(negedge clk);
      en = 1'b1;
      edge_cnt = 0;
      first_valid = 0;
      window(32'h7FFF_FFFE, 1'b0, 0, 1'b0);
      window(32'h8000_0001, 1'b1, 3, 1'b0);
      chk("first_valid_after_restore", 32'(first_valid), 32'd8);
      window(32'h8000_0004, 1'b1, 3, 1'b0);
      window(32'hFFFF_FFFF, 1'b1, 32767, 1'b1);
      window(32'h0000_0002, 1'b1, 3, 1'b0);
      window(32'd40002, 1'b1, 32767, 1'b1);
      window(32'd2, 1'b1, -32768, 1'b1);
      window(32'd7, 1'b1, 5, 1'b0);
      window(32'd32774, 1'b1, 32767, 1'b0);
      window(32'd6, 1'b1, -32768, 1'b0);
      window(32'd32774, 1'b1, 32767, 1'b1);

      // snapshot handshake with measurement disabled
      en = 1'b0;
      pos = 32'h1234;
      snap_if.snap_req = 1'b1;
      chk("snap_ack_before", 32'(snap_if.snap_ack), 32'd0);
      @(posedge clk);
      #1;
      chk("snap_ack_rise", 32'(snap_if.snap_ack), 32'd1);
      chk("snap_pos_cap", snap_if.snap_pos, 32'h1234);
      @(negedge clk);
      pos = 32'h5555;
      repeat (3) @(posedge clk);
      #1;
      chk("snap_pos_held", snap_if.snap_pos, 32'h1234);
      chk("snap_ack_held", 32'(snap_if.snap_ack), 32'd1);
      @(negedge clk);
      snap_if.snap_req = 1'b0;
      @(posedge clk);
      #1;
      chk("snap_ack_fall", 32'(snap_if.snap_ack), 32'd0);
      chk("snap_pos_after_fall", snap_if.snap_pos, 32'h1234);
      @(negedge clk);
      pos = 32'hABCD;
      snap_if.snap_req = 1'b1;
      @(posedge clk);
      #1;
      chk("snap_pos_recap", snap_if.snap_pos, 32'hABCD);

      // reset mid-operation
      @(negedge clk);
      en = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_vel", 32'(vel), 32'd0);
      chk("midrst_vel_sat", 32'(vel_sat), 32'd0);
      chk("midrst_snap_ack", 32'(snap_if.snap_ack), 32'd0);
      chk("midrst_snap_pos", snap_if.snap_pos, 32'd0);
      @(negedge clk);
      snap_if.snap_req = 1'b0;
      rst_n = 1'b1;
      edge_cnt = 0;
      first_valid = 0;
      window(32'd10, 1'b0, 0, 1'b0);
      window(32'd17, 1'b1, 7, 1'b0);
      chk("first_valid_after_rst", 32'(first_valid), 32'd8);
      en = 1'b0;

`ifdef QVEL_INDEX_EN
      pos = 32'd500;
      index = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("index_seen_early", 32'(index_seen), 32'd0);
      @(posedge clk);
      #1;
      chk("index_seen_set", 32'(index_seen), 32'd1);
      chk("index_pos_cap", index_pos, 32'd500);
      @(negedge clk);
      index = 1'b0;
      pos = 32'd600;
      repeat (3) @(posedge clk);
      @(negedge clk);
      index = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("index_second_ignored", index_pos, 32'd500);
      @(negedge clk);
      index = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      index_clr = 1'b1;
      @(posedge clk);
      #1;
      chk("index_clr", 32'(index_seen), 32'd0);
      @(negedge clk);
      index_clr = 1'b0;
      pos = 32'd700;
      index = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      index_clr = 1'b1;
      @(posedge clk);
      #1;
      chk("index_clr_wins", 32'(index_seen), 32'd0);
      @(negedge clk);
      index_clr = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("index_no_late_cap", 32'(index_seen), 32'd0);
      chk("index_pos_kept", index_pos, 32'd500);
      @(negedge clk);
      index = 1'b0;
`endif

      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_drained", 32'(expq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/quad_velocity.md
# quad_velocity

Velocity and position-capture stage sitting directly downstream of the quadrature encoder counter. Consumes the free-running 32-bit position count on the same clock, produces a saturated signed per-window position delta (velocity) with a valid strobe, and offers a four-phase snapshot handshake so the host interface can read a coherent position. Optionally latches position on an encoder index pulse.

## Interface

- PERIOD, 1000, sample window length in clk cycles; legal range 2..2^24
- VEL_W, 16, width of signed velocity output; legal range 8..32
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- pos  in  32  encoder position count, same clock domain, two's-complement wrap
- en  in  1  measurement enable
- vel  out  VEL_W  signed counts per window, saturated
- vel_valid  out  1  one-cycle strobe, vel updated this cycle
- vel_sat  out  1  vel of the current result was clamped
- snap_req  in  1  snapshot request, level, four-phase
- snap_ack  out  1  snapshot acknowledge
- snap_pos  out  32  captured position, stable while snap_ack high
- index  in  1  raw index input, asynchronous (present only with QVEL_INDEX_EN)
- index_clr  in  1  clears index_seen (only with QVEL_INDEX_EN)
- index_seen  out  1  sticky: index edge captured (only with QVEL_INDEX_EN)
- index_pos  out  32  position at index edge (only with QVEL_INDEX_EN)

## Operation

- Reset values: vel=0, vel_valid=0, vel_sat=0, snap_ack=0, snap_pos=0, index_seen=0, index_pos=0; timer=0; state=PRIME; prev=0.
- Timer counts 0..PERIOD-1 while en=1; tick = (timer==PERIOD-1); timer wraps to 0 on tick.
- FSM states PRIME, RUN.
  - PRIME: on tick, prev<=pos, go RUN; no vel_valid.
  - RUN: on tick, delta=pos-prev (32-bit modular subtraction, wrap of pos handled naturally), prev<=pos, vel<=sat(delta), vel_sat<=(clamped), vel_valid<=1.
  - en=0 (any state): timer<=0, state<=PRIME, vel_valid<=0; vel and vel_sat hold last values.
- Saturation: delta interpreted as signed 32-bit; clamp to [-(2^(VEL_W-1)), 2^(VEL_W-1)-1]. VEL_W=32 never saturates.
- Snapshot handshake (independent of en): if snap_req=1 and snap_ack=0: snap_pos<=pos, snap_ack<=1. snap_ack stays high while snap_req=1. When snap_req=0 and snap_ack=1: snap_ack<=0. snap_pos holds until next capture. New request requires ack to have returned low first.
- Reset asserted mid-operation returns everything to reset values immediately; first vel_valid after release comes no earlier than 2*PERIOD cycles.

## Timing

- vel, vel_sat, vel_valid registered; update in the cycle after the tick edge, using pos sampled at that edge. vel_valid high exactly one cycle per PERIOD in RUN.
- First vel_valid after en rises: 2*PERIOD cycles later.
- snap_ack rises one cycle after snap_req is sampled high; snap_pos valid same cycle as snap_ack. Falls one cycle after snap_req sampled low.
- Index: two-flop synchronizer plus edge-detect flop; index_pos/index_seen update 3 cycles after index rise is first sampled.

## Configuration

- QVEL_INDEX_EN defined: index, index_clr, index_seen, index_pos ports and synchronizer present. On synchronized rising edge with index_seen=0: index_pos<=pos, index_seen<=1. Further edges ignored while index_seen=1. index_clr=1 clears index_seen; simultaneous edge and index_clr: clear wins, no capture.
- Not defined: ports and logic absent; remaining behaviour unchanged.

## Structure

- Shared package: FSM state enum (PRIME, RUN), position width constant 32, saturation helper function.
- One sub-module natural: qvel_sync, two-flop synchronizer with rising-edge detect, reset to 0, used for index.

## Test plan

- PERIOD=4, VEL_W=16, en=1, pos increments by 1 per cycle -> first vel_valid at cycle 8 with vel=4, then every 4 cycles vel=4, vel_sat=0.
- pos steps from 0x7FFFFFFE up across 0x80000000 at +3 per window, then from 0xFFFFFFFF to 0x00000002 -> vel=3 every window, no glitch at wrap.
- pos jumps +40000 in one window (VEL_W=16) -> vel=32767, vel_sat=1; jump -40000 -> vel=-32768, vel_sat=1; next window +5 -> vel=5, vel_sat=0.
- en dropped mid-window then restored -> no vel_valid until 2*PERIOD after restore; vel holds prior value meanwhile.
- snap_req raised with pos=0x1234 -> snap_ack next cycle, snap_pos=0x1234, held while pos changes; snap_req low -> snap_ack low next cycle.
- QVEL_INDEX_EN: index pulse at pos=500 -> index_seen=1, index_pos=500 after 3 cycles; second pulse ignored; index_clr coincident with edge -> index_seen=0.
